// File: rtl/dbf_ch_dyn_apo_pkg.sv
// +--------------------------------------------------------------------------+
// | dbf_ch_dyn_apo_pkg : width defaults and FSM encoding for the DBF channel |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package dbf_ch_dyn_apo_pkg;

  localparam int DEF_INPUT_WD  = 12;
  localparam int DEF_APO_WD    = 16;
  localparam int DEF_DLY_WD    = 8;
  localparam int DEF_ZONE_WD   = 6;
  localparam int DEF_ZLEN_LOG2 = 6;
  localparam int DEF_LINE_LEN  = 4096;
  localparam int DEF_OUT_WD    = 32;
  localparam int DEF_DEPTH     = 2**DEF_DLY_WD;
  localparam int DEF_NZONE     = 2**DEF_ZONE_WD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dbf_ring_buf.sv
// +--------------------------------------------------------------------------+
// | dbf_ring_buf : sample ring, 1 write + 1 registered read, write-through   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dbf_ring_buf
  import dbf_ch_dyn_apo_pkg::*;
#(
  parameter int DATA_WD = DEF_INPUT_WD,
  parameter int ADDR_WD = DEF_DLY_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [ADDR_WD-1:0] waddr_i,
  input  logic [DATA_WD-1:0] wdata_i,
  input  logic [ADDR_WD-1:0] raddr_i,
  output logic [DATA_WD-1:0] rdata_o
);

  localparam int DEPTH = 2**ADDR_WD;

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [DATA_WD-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Zero delay reads the slot being written this cycle, so forward the input.
  always_ff @(posedge clk) begin
    if (rst_n) rdata_q <= '0;
    else       rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dbf_ch_dyn_apo.sv
// +--------------------------------------------------------------------------+
// | dbf_ch_dyn_apo : per-element receive channel with zoned delay/apodization|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dbf_ch_dyn_apo
  import dbf_ch_dyn_apo_pkg::*;
#(
  parameter int INPUT_WD  = DEF_INPUT_WD,
  parameter int APO_WD    = DEF_APO_WD,
  parameter int DLY_WD    = DEF_DLY_WD,
  parameter int ZONE_WD   = DEF_ZONE_WD,
  parameter int ZLEN_LOG2 = DEF_ZLEN_LOG2,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int OUT_WD    = DEF_OUT_WD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     tx_en_i,
  input  logic [INPUT_WD-1:0]      ch_in_i,
  input  logic [ZONE_WD-1:0]       lut_addr_i,
  input  logic [DLY_WD+APO_WD-1:0] lut_din_i,
  input  logic                     lut_we_i,
  output logic [OUT_WD-1:0]        dout_o,
  output logic                     dout_valid_o,
  output logic [INPUT_WD-1:0]      cd_dout_o,
  output logic                     busy_o,
  output logic                     line_done_o
);

  localparam int NZONE  = 2**ZONE_WD;
  localparam int CNT_WD = $clog2(LINE_LEN);
  localparam int P_WD   = INPUT_WD + APO_WD;

  state_e                    state_q;
  logic [DLY_WD-1:0]         wr_ptr_q;
  logic [CNT_WD-1:0]         cnt_q;
  logic                      busy_q;
  logic [DLY_WD+APO_WD-1:0]  lut_q [NZONE];

  logic                      accept;
  logic                      last;
  logic [31:0]               zone_raw;
  logic [ZONE_WD-1:0]        zone;
  logic [DLY_WD+APO_WD-1:0]  entry;
  logic [DLY_WD-1:0]         dly;
  logic [APO_WD-1:0]         apo;
  logic [DLY_WD-1:0]         rd_addr;
  logic                      zero_fill;
  logic [INPUT_WD-1:0]       rd_data;

  always_comb begin
    accept    = ((state_q == ST_ARM) || (state_q == ST_RUN)) && !start_i && !tx_en_i;
    last      = accept && (cnt_q == CNT_WD'(LINE_LEN - 1));
    zone_raw  = 32'(cnt_q) >> ZLEN_LOG2;
    zone      = (zone_raw > 32'(NZONE - 1)) ? ZONE_WD'(NZONE - 1) : zone_raw[ZONE_WD-1:0];
    entry     = lut_q[zone];
    dly       = entry[DLY_WD+APO_WD-1:APO_WD];
    apo       = entry[APO_WD-1:0];
    rd_addr   = wr_ptr_q - dly;
    zero_fill = 32'(cnt_q) < 32'(dly);
  end

  // Asynchronous LUT read: a same-cycle write to the read address lands after the read.
  always_ff @(posedge clk) begin
    if (lut_we_i) lut_q[lut_addr_i] <= lut_din_i;
  end

  dbf_ring_buf #(
    .DATA_WD (INPUT_WD),
    .ADDR_WD (DLY_WD)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (ch_in_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q  <= ST_ARM;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
          end
        end
        ST_ARM, ST_RUN: begin
          if (start_i) begin
            state_q  <= ST_ARM;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
          end else if (!tx_en_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_WD'(LINE_LEN - 1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic                       v1_q, zf1_q, last1_q;
  logic signed [APO_WD-1:0]   w1_q;
  logic                       v2_q, last2_q;
  logic signed [INPUT_WD-1:0] cd2_q;
  logic signed [P_WD-1:0]     p2_q;
  logic                       valid_q, line_done_q;
  logic [OUT_WD-1:0]          dout_q;
  logic [INPUT_WD-1:0]        cd_dout_q;

  logic signed [INPUT_WD-1:0] cd1;
  logic signed [P_WD-1:0]     prod;
  logic signed [P_WD:0]       biased;
  logic signed [P_WD:0]       rnd;
  logic [OUT_WD-1:0]          out_sat;

  always_comb begin
    cd1    = zf1_q ? '0 : rd_data;
    prod   = cd1 * w1_q;
    biased = {p2_q[P_WD-1], p2_q} + (P_WD+1)'(2**(APO_WD-2));
    rnd    = biased >>> (APO_WD - 1);
  end

  // The rounded value needs INPUT_WD+1 bits; narrower outputs must clamp.
  if (OUT_WD < INPUT_WD + 1) begin : g_sat
    localparam logic signed [P_WD:0] C_MAX = (P_WD+1)'((64'sd1 <<< (OUT_WD - 1)) - 64'sd1);
    localparam logic signed [P_WD:0] C_MIN = (P_WD+1)'(-(64'sd1 <<< (OUT_WD - 1)));
    always_comb begin
      if (rnd > C_MAX)      out_sat = OUT_WD'(C_MAX);
      else if (rnd < C_MIN) out_sat = OUT_WD'(C_MIN);
      else                  out_sat = OUT_WD'(rnd);
    end
  end else begin : g_nosat
    assign out_sat = OUT_WD'(rnd);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      v1_q        <= 1'b0;
      zf1_q       <= 1'b0;
      last1_q     <= 1'b0;
      w1_q        <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      cd2_q       <= '0;
      p2_q        <= '0;
      valid_q     <= 1'b0;
      line_done_q <= 1'b0;
      dout_q      <= '0;
      cd_dout_q   <= '0;
    end else begin
      v1_q        <= accept;
      zf1_q       <= zero_fill;
      last1_q     <= last;
      w1_q        <= apo;
      v2_q        <= v1_q;
      last2_q     <= last1_q;
      cd2_q       <= cd1;
      p2_q        <= prod;
      valid_q     <= v2_q;
      line_done_q <= v2_q && last2_q;
      dout_q      <= v2_q ? out_sat : '0;
      cd_dout_q   <= v2_q ? cd2_q : '0;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign cd_dout_o    = cd_dout_q;
  assign busy_o       = busy_q;
  assign line_done_o  = line_done_q;

endmodule

`default_nettype wire
